// File: rtl/cache_block_streamer_pkg.sv
// Shared geometry, state encoding and element slicing for the cache block streamer
// and the cache RAM that feeds it.
package cache_block_streamer_pkg;

  localparam int ELEMENT_WIDTH      = 32;
  localparam int ELEMENTS_PER_BLOCK = 4;
  localparam int LG_EPB             = 2;
  localparam int WIDTH              = ELEMENT_WIDTH * ELEMENTS_PER_BLOCK;
  localparam int LG_DEPTH           = 6;
  localparam int LG_COUNT           = 10;

  // Width wide enough to hold offset + count + rounding without overflow.
  localparam int SPAN_W = LG_COUNT + 1;

  localparam logic [LG_EPB-1:0] LAST_INDEX = LG_EPB'(ELEMENTS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Element 0 is the least significant slice of a word.
  function automatic logic [ELEMENT_WIDTH-1:0] element_slice(
    input logic [WIDTH-1:0]  word,
    input logic [LG_EPB-1:0] index
  );
    return word[int'(index) * ELEMENT_WIDTH +: ELEMENT_WIDTH];
  endfunction

endpackage

// File: rtl/cache_word_fifo2.sv
// Two-entry word FIFO that absorbs the one-cycle RAM read latency.
// Push and pop in the same cycle are allowed and leave the occupancy unchanged.
module cache_word_fifo2
  import cache_block_streamer_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: data storage has no reset; validity is tracked by count alone,
  // which keeps the reset fan-out off the wide data registers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cache_block_streamer.sv
// Streams a run of elements out of the cache RAM: issues sequential word reads
// and serializes each word into elements on a valid/ready stream.
module cache_block_streamer
  import cache_block_streamer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [LG_DEPTH-1:0]      req_addr,
  input  logic [LG_EPB-1:0]        req_offset,
  input  logic [LG_COUNT-1:0]      req_count,
  output logic                     ram_en,
  output logic [LG_DEPTH-1:0]      ram_addr,
  input  logic [WIDTH-1:0]         ram_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ELEMENT_WIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  state_t               state;
  logic [LG_DEPTH-1:0]  addr;
  logic [LG_EPB-1:0]    index;
  logic [LG_COUNT-1:0]  elements_left;
  logic [SPAN_W-1:0]    words_left;
  logic                 in_flight;

  logic [1:0]           buf_count;
  logic [WIDTH-1:0]     buf_head;
  logic [1:0]           occupancy;
  logic [SPAN_W-1:0]    span;
  logic                 fire;
  logic                 final_element;
  logic                 pop;

  // Rounded-up word count covering offset..offset+count-1.
  assign span = SPAN_W'(req_count) + SPAN_W'(req_offset) + SPAN_W'(ELEMENTS_PER_BLOCK - 1);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Buffered plus in-flight words never exceed two, so the FIFO cannot overflow.
  assign occupancy = buf_count + {1'b0, in_flight};
  assign ram_en    = (words_left != '0) && (occupancy < 2'd2);
  assign ram_addr  = addr;

  assign final_element = (elements_left == LG_COUNT'(1));
  assign out_valid     = (buf_count != 2'd0);
  assign out_data      = element_slice(buf_head, index);
  assign out_last      = out_valid && final_element;
  assign fire          = out_valid && out_ready;
  assign pop           = fire && ((index == LAST_INDEX) || final_element);

  cache_word_fifo2 #(
    .W (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .clear     (reset),
    .push      (in_flight),
    .push_data (ram_dout),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      index         <= '0;
      elements_left <= '0;
      words_left    <= '0;
      in_flight     <= 1'b0;
    end else begin
      in_flight <= ram_en;
      if (ram_en) begin
        addr       <= addr + 1'b1;
        words_left <= words_left - 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid && (req_count != '0)) begin
            state         <= STREAM;
            addr          <= req_addr;
            index         <= req_offset;
            elements_left <= req_count;
            words_left    <= span >> LG_EPB;
          end
        end
        STREAM: begin
          // Index wraps to 0 on a word boundary, which starts the next word.
          if (fire) begin
            index         <= index + 1'b1;
            elements_left <= elements_left - 1'b1;
            if (final_element) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_block_streamer.sv
// Scoreboard bench for cache_block_streamer with a behavioural RAM and element model.
module tb_cache_block_streamer;
  import cache_block_streamer_pkg::*;

  typedef struct {
    logic [ELEMENT_WIDTH-1:0] data;
    logic                     last;
    logic                     word_end;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [LG_DEPTH-1:0]      req_addr = '0;
  logic [LG_EPB-1:0]        req_offset = '0;
  logic [LG_COUNT-1:0]      req_count = '0;
  logic                     ram_en;
  logic [LG_DEPTH-1:0]      ram_addr;
  logic [WIDTH-1:0]         ram_dout = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [ELEMENT_WIDTH-1:0] out_data;
  logic                     out_last;
  logic                     busy;

  logic [WIDTH-1:0] mem [1 << LG_DEPTH];
  exp_t             exp_q[$];
  int               addr_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               outstanding = 0;
  int               ready_mode = 0;
  int               phase = 0;

  cache_block_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_offset (req_offset),
    .req_count  (req_count),
    .ram_en     (ram_en),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: element k of a request is element (offset+k) of the run
  // starting at word addr, with words wrapping modulo the RAM depth.
  task automatic expect_request(input int a, input int o, input int c);
    logic [WIDTH-1:0] w;
    exp_t             x;
    int               e;
    int               words;
    for (int k = 0; k < c; k++) begin
      e = o + k;
      w = mem[(a + e / ELEMENTS_PER_BLOCK) % (1 << LG_DEPTH)];
      x.data     = w[(e % ELEMENTS_PER_BLOCK) * ELEMENT_WIDTH +: ELEMENT_WIDTH];
      x.last     = (k == c - 1);
      x.word_end = (e % ELEMENTS_PER_BLOCK == ELEMENTS_PER_BLOCK - 1) || (k == c - 1);
      exp_q.push_back(x);
    end
    words = (c == 0) ? 0 : (o + c + ELEMENTS_PER_BLOCK - 1) / ELEMENTS_PER_BLOCK;
    for (int i = 0; i < words; i++) addr_q.push_back((a + i) % (1 << LG_DEPTH));
  endtask

  task automatic send_req(input int a, input int o, input int c);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (req_ready) break;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    req_addr   = LG_DEPTH'(a);
    req_offset = LG_EPB'(o);
    req_count  = LG_COUNT'(c);
    req_valid  = 1'b1;
    expect_request(a, o, c);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) return;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
  endtask

  // Consumer ready: always, the 1,0,0,1 pattern, or random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    phase++;
  end

  // Monitor: read issue order, buffer bound, element order and stall stability.
  exp_t                     mon_e;
  logic                     prev_stall = 1'b0;
  logic [ELEMENT_WIDTH-1:0] prev_data;
  logic                     prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        if (addr_q.size() == 0) check("spurious_ram_en", 1, 0);
        else check("ram_addr", 64'(ram_addr), 64'(addr_q.pop_front()));
        check("words_outstanding_lt2", 64'(outstanding < 2), 1);
        outstanding++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 1);
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_element", 64'(out_data), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.data));
          check("out_last", 64'(out_last), 64'(mon_e.last));
          if (mon_e.word_end) outstanding--;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << LG_DEPTH); i++)
      mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem[5] = {32'hD, 32'hC, 32'hB, 32'hA};
    mem[7] = {32'h73, 32'h72, 32'h71, 32'h70};
    mem[8] = {32'h83, 32'h82, 32'h81, 32'h80};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_ram_en", 64'(ram_en), 0);
    check("rst_ram_addr", 64'(ram_addr), 0);

    // Single word, full throughput, two-cycle latency.
    send_req(5, 0, 4);
    @(negedge clk);
    check("lat_issue_ram_en", 64'(ram_en), 1);
    check("lat_cycle1_valid", 64'(out_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 0);
    check("single_read", 64'(ram_en), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_valid", 64'(out_valid), 1);
    end
    @(negedge clk);
    check("done_busy", 64'(busy), 0);
    wait_drain();

    // Offset spanning two words.
    send_req(7, 2, 4);
    wait_drain();

    // Backpressure 1,0,0,1.
    ready_mode = 1;
    send_req(0, 0, 12);
    wait_drain();
    ready_mode = 0;

    // Address wrap.
    send_req(63, 0, 8);
    wait_drain();

    // Zero-length request.
    send_req(9, 3, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_ram_en", 64'(ram_en), 0);
      check("zero_out_valid", 64'(out_valid), 0);
      check("zero_req_ready", 64'(req_ready), 1);
    end

    // Reset in the middle of a stream.
    send_req(10, 0, 16);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush_model();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_req_ready", 64'(req_ready), 1);
    @(negedge clk);
    check("midrst_no_stale", 64'(out_valid), 0);
    send_req(5, 0, 4);
    wait_drain();

    // Randomized requests, issued back to back.
    for (int n = 0; n < 30; n++) begin
      ready_mode = $urandom_range(0, 2);
      send_req($urandom_range(0, 63), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
    end
    wait_drain();
    repeat (4) @(negedge clk);
    check("final_exp_empty", 64'(exp_q.size()), 0);
    check("final_addr_empty", 64'(addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
